// File: rtl/smp_pkg.sv
// -----------------------------------------------------------------------------
// smp_pkg
// Shared types and constants for the SMP debug/run controller.
//   state_t  : global halt/run sequencer states
//   gcmd_t   : address-1 write command bits {clear, sync_stop, run_all, halt_all}
//   gstat_t  : address-1 read status word layout
//   PE_*     : per-core command encodings {step, halt, run}
// -----------------------------------------------------------------------------
package smp_pkg;

    localparam int MAX_CPUS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT_ISSUE,
        ST_HALT_WAIT,
        ST_RUN_ISSUE,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic clear;
        logic sync_stop;
        logic run_all;
        logic halt_all;
    } gcmd_t;

    typedef struct packed {
        logic [11:0]         rsvd_hi;
        logic [MAX_CPUS-1:0] halted;
        logic [3:0]          rsvd_mid;
        logic [MAX_CPUS-1:0] trig;
        logic [4:0]          rsvd_lo;
        logic                sync_stop;
        logic                timeout;
        logic                busy;
    } gstat_t;

    localparam logic [2:0] PE_RUN  = 3'b001;
    localparam logic [2:0] PE_HALT = 3'b010;
    localparam logic [2:0] PE_STEP = 3'b100;

endpackage

// File: rtl/smp_pe.sv
// -----------------------------------------------------------------------------
// smp_pe
// Per-core run/halt/step control element.
//   clk, rst_n : clock, asynchronous active-low reset
//   write      : command strobe
//   writedata  : {step, halt, run}; halt wins over run
//   halt       : halt request level (BSP core comes out of reset running)
//   step       : one-cycle single-step pulse
// -----------------------------------------------------------------------------
module smp_pe
    import smp_pkg::*;
#(
    parameter bit IS_BSP = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       write,
    input  logic [2:0] writedata,
    output logic       halt,
    output logic       step
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt <= ~IS_BSP;
            step <= 1'b0;
        end else begin
            step <= write & (|(writedata & PE_STEP));
            if (write) begin
                if (|(writedata & PE_HALT)) begin
                    halt <= 1'b1;
                end else if (|(writedata & PE_RUN)) begin
                    halt <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/smp_ctrl.sv
// -----------------------------------------------------------------------------
// smp_ctrl
// SMP debug/run controller: one smp_pe per core behind a 32-bit Avalon-MM
// slave, plus global halt-all/run-all sequencing and stop-the-world mode.
//   clk, rst_n        : clock, asynchronous active-low reset
//   avl_address       : 0 = per-core byte lanes, 1 = global control/status
//   avl_read/write    : Avalon strobes; avl_writedata write data
//   avl_readdata      : combinational read data
//   avl_waitrequest   : stall while a global command is in flight
//   cpu_alive/halted  : per-core status inputs
//   breakpoint        : per-core breakpoint level
//   halt, step        : per-core outputs from the smp_pe instances
// -----------------------------------------------------------------------------
module smp_ctrl
    import smp_pkg::*;
#(
    parameter int NUM_CPUS = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                avl_address,
    input  logic                avl_read,
    input  logic                avl_write,
    input  logic [31:0]         avl_writedata,
    output logic [31:0]         avl_readdata,
    output logic                avl_waitrequest,
    input  logic [NUM_CPUS-1:0] cpu_alive,
    input  logic [NUM_CPUS-1:0] cpu_halted,
    input  logic [NUM_CPUS-1:0] breakpoint,
    output logic [NUM_CPUS-1:0] halt,
    output logic [NUM_CPUS-1:0] step
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t              state, state_nx;
    gcmd_t               gcmd;
    gstat_t              status;
    logic [CNT_W-1:0]    wait_cnt;
    logic                held;
    logic                sync_stop;
    logic                timeout_flag;
    logic [MAX_CPUS-1:0] trig_mask;
    logic [NUM_CPUS-1:0] bp_q;
    logic [NUM_CPUS-1:0] bp_edge;
    logic                bp_trig;
    logic                host_halt_wr;
    logic                host_run_wr;
    logic                cfg_wr;
    logic                all_halted;
    logic                pe_force;
    logic [2:0]          fsm_cmd;
    logic [MAX_CPUS-1:0] alive_p, bp_p, halted_p;
    logic                unused_wdata;

    assign gcmd         = gcmd_t'(avl_writedata[3:0]);
    assign bp_edge      = breakpoint & ~bp_q;
    assign bp_trig      = sync_stop & (|bp_edge);
    assign host_halt_wr = avl_write & avl_address & gcmd.halt_all;
    assign host_run_wr  = avl_write & avl_address & gcmd.run_all & ~gcmd.halt_all;
    assign cfg_wr       = avl_write & avl_address & ~avl_waitrequest;
    // Dead cores count as halted so they never block completion.
    assign all_halted   = &(cpu_halted | ~cpu_alive);
    assign unused_wdata = ^avl_writedata;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // ---------------- next-state logic ----------------
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (host_halt_wr || bp_trig) state_nx = ST_HALT_ISSUE;
                else if (host_run_wr)        state_nx = ST_RUN_ISSUE;
            end
            ST_HALT_ISSUE: state_nx = ST_HALT_WAIT;
            ST_HALT_WAIT: begin
                if (all_halted || wait_cnt == CNT_MAX)
                    state_nx = held ? ST_DONE : ST_IDLE;
            end
            ST_RUN_ISSUE: state_nx = ST_DONE;
            ST_DONE:      state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        avl_waitrequest = 1'b0;
        pe_force        = 1'b0;
        fsm_cmd         = PE_RUN;
        case (state)
            ST_IDLE:       avl_waitrequest = host_halt_wr | host_run_wr;
            ST_HALT_ISSUE: begin
                avl_waitrequest = avl_read | avl_write;
                pe_force        = 1'b1;
                fsm_cmd         = PE_HALT;
            end
            ST_HALT_WAIT:  avl_waitrequest = avl_read | avl_write;
            ST_RUN_ISSUE: begin
                avl_waitrequest = avl_read | avl_write;
                pe_force        = 1'b1;
                fsm_cmd         = PE_RUN;
            end
            default:       avl_waitrequest = 1'b0;
        endcase
    end

    // ---------------- control/status registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_q         <= '0;
            held         <= 1'b0;
            wait_cnt     <= '0;
            sync_stop    <= 1'b0;
            timeout_flag <= 1'b0;
            trig_mask    <= '0;
        end else begin
            bp_q <= breakpoint;
            if (state == ST_IDLE) held <= host_halt_wr;

            if (state == ST_HALT_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == ST_HALT_WAIT && wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (state == ST_HALT_WAIT && wait_cnt == CNT_MAX && !all_halted)
                timeout_flag <= 1'b1;

            if (cfg_wr) begin
                sync_stop <= gcmd.sync_stop;
                if (gcmd.clear) begin
                    timeout_flag <= 1'b0;
                    trig_mask    <= '0;
                end
            end

            // Only an IDLE trigger latches; later edges are ignored.
            if (state == ST_IDLE && bp_trig) trig_mask <= MAX_CPUS'(bp_edge);
        end
    end

    // ---------------- read data ----------------
    assign alive_p  = MAX_CPUS'(cpu_alive);
    assign bp_p     = MAX_CPUS'(breakpoint);
    assign halted_p = MAX_CPUS'(cpu_halted);

    always_comb begin
        status           = '0;
        status.busy      = (state != ST_IDLE);
        status.timeout   = timeout_flag;
        status.sync_stop = sync_stop;
        status.trig      = trig_mask;
        status.halted    = halted_p;
    end

    always_comb begin
        avl_readdata = '0;
        if (avl_address) begin
            avl_readdata = status;
        end else begin
            for (int i = 0; i < MAX_CPUS; i++)
                avl_readdata[8*i +: 3] = {alive_p[i], bp_p[i], halted_p[i]};
        end
    end

    // ---------------- per-core elements ----------------
    // FSM commands override the host lane; host writes are stalled meanwhile.
    for (genvar i = 0; i < NUM_CPUS; i++) begin : g_pe
        smp_pe #(
            .IS_BSP (i == 0)
        ) u_pe (
            .clk       (clk),
            .rst_n     (rst_n),
            .write     (pe_force | (avl_write & ~avl_address & ~avl_waitrequest)),
            .writedata (pe_force ? fsm_cmd : avl_writedata[8*i +: 3]),
            .halt      (halt[i]),
            .step      (step[i])
        );
    end

endmodule

// File: tb/tb_smp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_smp_ctrl
// Self-checking bench for smp_ctrl (4 cores, TIMEOUT=16). A simple core model
// reports halted a programmable number of cycles after its halt input rises.
// -----------------------------------------------------------------------------
module tb_smp_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        avl_address = 1'b0;
    logic        avl_read = 1'b0;
    logic        avl_write = 1'b0;
    logic [31:0] avl_writedata = '0;
    logic [31:0] avl_readdata;
    logic        avl_waitrequest;
    logic [3:0]  cpu_alive;
    logic [3:0]  cpu_halted;
    logic [3:0]  breakpoint;
    logic [3:0]  halt;
    logic [3:0]  step;

    int          errors = 0;
    int          checks = 0;

    // core model: halted = halt seen lat cycles ago (lat=0: same cycle)
    int          lat = 0;
    logic [3:0]  never_halt = '0;
    logic [7:0]  hist [4] = '{default: '0};

    // expected per-core state for lane writes
    logic [3:0]  m_halt;
    logic [3:0]  m_step;

    smp_ctrl #(.NUM_CPUS(4), .TIMEOUT(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .avl_address     (avl_address),
        .avl_read        (avl_read),
        .avl_write       (avl_write),
        .avl_writedata   (avl_writedata),
        .avl_readdata    (avl_readdata),
        .avl_waitrequest (avl_waitrequest),
        .cpu_alive       (cpu_alive),
        .cpu_halted      (cpu_halted),
        .breakpoint      (breakpoint),
        .halt            (halt),
        .step            (step)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        for (int i = 0; i < 4; i++) hist[i] <= {hist[i][6:0], halt[i]};

    always_comb begin
        cpu_halted = '0;
        for (int i = 0; i < 4; i++) begin
            if (lat == 0) cpu_halted[i] = halt[i];
            else          cpu_halted[i] = hist[i][lat-1];
            cpu_halted[i] = cpu_halted[i] & cpu_alive[i] & ~never_halt[i];
        end
    end

    // ---------------- bus helpers ----------------
    task automatic bus_write(input logic a, input logic [31:0] d, output int stalls);
        bit done = 0;
        avl_address = a; avl_writedata = d; avl_write = 1'b1;
        stalls = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!avl_waitrequest) begin done = 1; break; end
            stalls++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL bus_write: waitrequest still high after %0d cycles, required release", stalls);
        end
        @(posedge clk); #1;
        avl_write = 1'b0;
    endtask

    task automatic bus_read(input logic a, output logic [31:0] d);
        bit done = 0;
        avl_address = a; avl_read = 1'b1;
        d = 'x;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!avl_waitrequest) begin d = avl_readdata; done = 1; break; end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL bus_read: waitrequest never released, required release");
        end
        @(posedge clk); #1;
        avl_read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [31:0] d;
        cpu_alive = 4'b0001; breakpoint = '0;
        rst_n = 1'b1; #1; rst_n = 1'b0;
        idle(2);
        checks++; if (halt !== 4'b1110) begin errors++; $display("FAIL reset_halt: got %b required 1110", halt); end
        checks++; if (step !== 4'b0000) begin errors++; $display("FAIL reset_step: got %b required 0000", step); end
        checks++; if (avl_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitreq: got %b required 0", avl_waitrequest); end
        rst_n = 1'b1;
        m_halt = 4'b1110; m_step = '0;
        bus_read(1'b0, d);
        checks++; if (d !== 32'h0000_0004) begin errors++; $display("FAIL reset_rd0: got %h required 00000004", d); end
        bus_read(1'b1, d);
        checks++; if (d !== 32'h0000_0000) begin errors++; $display("FAIL reset_rd1: got %h required 00000000", d); end
    endtask

    task automatic test_core_run;
        int st;
        cpu_alive = 4'b1111; lat = 5;
        bus_write(1'b0, 32'h0000_0100, st);
        m_halt[1] = 1'b0;
        checks++; if (st !== 0) begin errors++; $display("FAIL core_run_stall: got %0d required 0", st); end
        checks++; if (halt !== m_halt) begin errors++; $display("FAIL core_run_halt: got %b required %b", halt, m_halt); end
    endtask

    task automatic test_random_lanes;
        int st;
        logic [31:0] d, exp;
        for (int n = 0; n < 20; n++) begin
            d = $urandom();
            for (int i = 0; i < 4; i++) begin
                if (d[8*i+1])    m_halt[i] = 1'b1;
                else if (d[8*i]) m_halt[i] = 1'b0;
                m_step[i] = d[8*i+2];
            end
            bus_write(1'b0, d, st);
            checks++; if (st !== 0) begin errors++; $display("FAIL lane_stall: got %0d required 0", st); end
            checks++; if (halt !== m_halt || step !== m_step)
                begin errors++; $display("FAIL lane_write %h: got halt=%b step=%b required halt=%b step=%b", d, halt, step, m_halt, m_step); end
        end
        idle(8);
        checks++; if (step !== 4'b0000) begin errors++; $display("FAIL step_pulse: got %b required 0000", step); end
        for (int n = 0; n < 8; n++) begin
            cpu_alive  = 4'($urandom_range(0, 15));
            breakpoint = 4'($urandom_range(0, 15));
            #1;
            exp = '0;
            for (int i = 0; i < 4; i++) exp[8*i +: 3] = {cpu_alive[i], breakpoint[i], cpu_halted[i]};
            bus_read(1'b0, d);
            checks++; if (d !== exp) begin errors++; $display("FAIL lane_read: got %h required %h", d, exp); end
        end
        cpu_alive = 4'b1111; breakpoint = '0;
        idle(2);
    endtask

    task automatic test_halt_all;
        int st;
        logic [31:0] d;
        bus_write(1'b1, 32'h2, st);
        checks++; if (st !== 2 || halt !== 4'b0000) begin errors++; $display("FAIL run_all: got stalls=%0d halt=%b required 2/0000", st, halt); end
        idle(8);
        lat = 5;
        bus_write(1'b1, 32'h1, st);
        checks++; if (st !== 8) begin errors++; $display("FAIL halt_all_stall: got %0d required 8", st); end
        checks++; if (halt !== 4'b1111) begin errors++; $display("FAIL halt_all_halt: got %b required 1111", halt); end
        bus_read(1'b1, d);
        checks++; if (d !== 32'h000F_0000) begin errors++; $display("FAIL halt_all_status: got %h required 000F0000", d); end
        // all cores already halted: minimum latency
        bus_write(1'b1, 32'h1, st);
        checks++; if (st !== 3) begin errors++; $display("FAIL halt_all_prehalted: got %0d required 3", st); end
    endtask

    task automatic test_random_halt_run;
        int st, exp;
        for (int n = 0; n < 6; n++) begin
            cpu_alive = 4'($urandom_range(0, 15));
            lat = $urandom_range(0, 6);
            bus_write(1'b1, 32'h2, st);
            checks++; if (st !== 2 || halt !== 4'b0000) begin errors++; $display("FAIL rnd_run: got stalls=%0d halt=%b required 2/0000", st, halt); end
            idle(8);
            exp = (cpu_alive != 0) ? 3 + lat : 3;
            bus_write(1'b1, 32'h1, st);
            checks++; if (st !== exp || halt !== 4'b1111)
                begin errors++; $display("FAIL rnd_halt alive=%b lat=%0d: got stalls=%0d halt=%b required %0d/1111", cpu_alive, lat, st, halt, exp); end
        end
        cpu_alive = 4'b1111;
    endtask

    task automatic test_priority;
        int st;
        bus_write(1'b1, 32'h2, st);
        idle(8);
        lat = 2;
        bus_write(1'b1, 32'h3, st);
        checks++; if (st !== 5) begin errors++; $display("FAIL priority_stall: got %0d required 5", st); end
        checks++; if (halt !== 4'b1111) begin errors++; $display("FAIL priority_halt: got %b required 1111", halt); end
    endtask

    task automatic test_sync_stop;
        int st;
        logic [31:0] d;
        bus_write(1'b1, 32'h4, st);
        checks++; if (st !== 0) begin errors++; $display("FAIL sync_cfg_stall: got %0d required 0", st); end
        bus_write(1'b0, 32'h0101_0101, st);
        checks++; if (halt !== 4'b0000) begin errors++; $display("FAIL sync_release: got %b required 0000", halt); end
        idle(8);
        lat = 3;
        breakpoint = 4'b0100;
        idle(1);
        breakpoint = 4'b0000;
        checks++; if (halt !== 4'b0000) begin errors++; $display("FAIL sync_early: got %b required 0000", halt); end
        idle(1);
        checks++; if (halt !== 4'b1111) begin errors++; $display("FAIL sync_halt: got %b required 1111", halt); end
        checks++; if (avl_waitrequest !== 1'b0) begin errors++; $display("FAIL sync_nostall: got %b required 0", avl_waitrequest); end
        // a second edge while waiting must not replace the first trigger
        breakpoint = 4'b0010;
        idle(1);
        breakpoint = 4'b0000;
        idle(10);
        bus_read(1'b1, d);
        checks++; if (d !== 32'h000F_0404) begin errors++; $display("FAIL sync_status: got %h required 000F0404", d); end
        bus_write(1'b1, 32'h8, st);
        bus_read(1'b1, d);
        checks++; if (d !== 32'h000F_0000) begin errors++; $display("FAIL sync_clear: got %h required 000F0000", d); end
    endtask

    task automatic test_timeout;
        int st;
        logic [31:0] d;
        bus_write(1'b1, 32'h2, st);
        idle(8);
        lat = 1; never_halt = 4'b1000;
        bus_write(1'b1, 32'h1, st);
        checks++; if (st !== 19) begin errors++; $display("FAIL timeout_stall: got %0d required 19", st); end
        bus_read(1'b1, d);
        checks++; if (d !== 32'h0007_0002) begin errors++; $display("FAIL timeout_flag: got %h required 00070002", d); end
        bus_write(1'b1, 32'h8, st);
        bus_read(1'b1, d);
        checks++; if (d !== 32'h0007_0000) begin errors++; $display("FAIL timeout_clear: got %h required 00070000", d); end
        never_halt = '0;
    endtask

    task automatic test_reset_mid;
        int st;
        bus_write(1'b1, 32'h2, st);
        idle(8);
        lat = 6;
        avl_address = 1'b1; avl_writedata = 32'h1; avl_write = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0; avl_write = 1'b0;
        #1;
        checks++; if (halt !== 4'b1110 || step !== 4'b0000) begin errors++; $display("FAIL midreset_outs: got halt=%b step=%b required 1110/0000", halt, step); end
        checks++; if (avl_waitrequest !== 1'b0 || avl_readdata[0] !== 1'b0)
            begin errors++; $display("FAIL midreset_idle: got waitreq=%b busy=%b required 0/0", avl_waitrequest, avl_readdata[0]); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(10);
        bus_write(1'b1, 32'h1, st);
        checks++; if (st !== 9 || halt !== 4'b1111) begin errors++; $display("FAIL midreset_reissue: got stalls=%0d halt=%b required 9/1111", st, halt); end
    endtask

    initial begin
        test_reset();
        test_core_run();
        test_random_lanes();
        test_halt_all();
        test_random_halt_run();
        test_priority();
        test_sync_stop();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
